mips_fetch_unit: RTL and testbench

Fetch stage of the MIPS32 datapath, placed directly upstream of the byte-addressed, little-endian, combinational-read instruction memory. It holds the program counter and drives it out as the fetch address. It captures the returned 32-bit word into a fetch/decode output register and applies sequential, branch, jump and jump-register redirects from decode. It also detects out-of-range and misaligned fetches and halts on them.

---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/mips_pc_next.sv | 43 ++++
 rtl/mips_fetch_unit.sv | 87 ++++++++
 tb/tb_mips_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips_fetch_pkg;

  typedef enum logic {RUN, HALT} fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {SEQ, BR, J, JR} redirect_sel_t;

  // Branch offsets are word offsets relative to the delay-slot-free PC+4.
  function automatic logic [31:0] branch_target(logic [31:0] pc_plus4, logic [15:0] offset);
    return pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/mips_pc_next.sv
// Next-PC selection and fetch-address fault detection for the fetch stage.
module mips_pc_next
  import mips_fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic          [31:0] pc,
  input  logic          [31:0] if_pc_plus4,
  input  logic                 accept,
  input  logic                 branch_taken,
  input  logic          [15:0] branch_offset,
  input  logic                 jump,
  input  logic          [25:0] jump_target,
  input  logic                 jump_reg,
  input  logic          [31:0] jr_target,
  output redirect_sel_t        sel,
  output logic          [31:0] next_pc,
  output logic                 target_fault,
  output logic                 pc_fault
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - INSTR_BYTES);

  always_comb begin
    sel = SEQ;
    if (accept) begin
      if (jump_reg)          sel = JR;
      else if (jump)         sel = J;
      else if (branch_taken) sel = BR;
    end

    unique case (sel)
      JR:      next_pc = jr_target;
      J:       next_pc = {if_pc_plus4[31:28], jump_target, 2'b00};
      BR:      next_pc = branch_target(if_pc_plus4, branch_offset);
      default: next_pc = pc + 32'(INSTR_BYTES);
    endcase

    target_fault = (sel != SEQ) && ((next_pc[1:0] != 2'b00) || (next_pc > LAST_ADDR));
    pc_fault     = pc > LAST_ADDR;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS32 fetch stage: PC register, fetch/decode output register, redirects and
// halt-on-fault for out-of-range or misaligned fetch addresses.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instrn_address,
  input  logic [31:0] instrn,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic        if_valid,
  output logic [31:0] if_instrn,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  redirect_sel_t sel;
  logic [31:0]   next_pc;
  logic          target_fault;
  logic          pc_fault;

  assign instrn_address = pc_q;

  mips_pc_next #(
    .IMEM_BYTES(IMEM_BYTES)
  ) u_pc_next (
    .pc           (pc_q),
    .if_pc_plus4  (if_pc_plus4),
    .accept       (if_valid & ~stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .sel          (sel),
    .next_pc      (next_pc),
    .target_fault (target_fault),
    .pc_fault     (pc_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      if_instrn   <= 32'h0;
      if_pc_plus4 <= 32'h0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else if (state_q == RUN && !stall) begin
      // Range fault wins over a redirect: the fetch being squashed is bad anyway.
      if (pc_fault) begin
        state_q     <= HALT;
        fetch_fault <= 1'b1;
        if_valid    <= 1'b0;
      end else if (sel != SEQ) begin
        if_valid <= 1'b0;
        if (target_fault) begin
          state_q     <= HALT;
          fetch_fault <= 1'b1;
        end else begin
          pc_q <= next_pc;
        end
      end else begin
        if_instrn   <= instrn;
        if_pc_plus4 <= next_pc;
        if_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
        pc_q        <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus random
// redirect/stall traffic against a behavioural fetch model and capture scoreboard.
module tb_mips_fetch_unit;

  localparam int unsigned IMEM_BYTES = 32;
  localparam int unsigned WORDS      = IMEM_BYTES / 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] LAST       = 32'(IMEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instrn_address;
  logic [31:0] instrn;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instrn;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [WORDS];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] count;
  } cap_t;
  cap_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid, m_halt;

  mips_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instrn_address(instrn_address),
    .instrn        (instrn),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .if_valid      (if_valid),
    .if_instrn     (if_instrn),
    .if_pc_plus4   (if_pc_plus4),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (instrn_address < IMEM_BYTES) instrn = mem[instrn_address[4:2]];
    else                             instrn = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the fetch stage, described from the behavioural rules.
  task automatic model_edge();
    logic [31:0] tgt;
    if (m_halt || stall) return;
    if (m_pc > LAST) begin
      m_halt  = 1;
      m_valid = 0;
    end else if (m_valid && (jump_reg || jump || branch_taken)) begin
      if (jump_reg)  tgt = jr_target;
      else if (jump) tgt = (m_pc4 & 32'hF000_0000) | (32'(jump_target) * 4);
      else           tgt = m_pc4 + 32'(int'($signed(branch_offset)) * 4);
      if ((tgt % 4) != 0 || tgt > LAST) m_halt = 1;
      else                              m_pc = tgt;
      m_valid = 0;
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = m_pc + 4;
      m_count = m_count + 1;
      m_valid = 1;
      m_pc    = m_pc + 4;
      exp_q.push_back('{instr: m_instr, pc4: m_pc4, count: m_count});
    end
  endtask

  task automatic check_state();
    chk("instrn_address", instrn_address, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_halt));
    chk("fetch_count", fetch_count, m_count);
    chk("if_instrn", if_instrn, m_instr);
    chk("if_pc_plus4", if_pc_plus4, m_pc4);
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; branch_offset = 16'h0;
    jump = 0; jump_target = 26'h0; jump_reg = 0; jr_target = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks its effect before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_addr", instrn_address, RESET_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_count = 0; m_valid = 0; m_halt = 0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected capture each time the DUT reports a new fetch.
  initial begin : monitor
    logic [31:0] last_count;
    cap_t        e;
    last_count = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && fetch_count != last_count) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got count %0d expected no capture", fetch_count);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", if_instrn, e.instr);
          chk("sb_pc4", if_pc_plus4, e.pc4);
          chk("sb_count", fetch_count, e.count);
          chk("sb_valid", 32'(if_valid), 32'd1);
        end
      end
      last_count = fetch_count;
    end
  end

  initial begin : stimulus
    int r;
    int halt_cycles;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
    mem[0] = 32'h2008_0005;
    #3;

    // Reset and first fetch, then run off the end of memory
    do_reset();
    cycle();
    chk("first_instr", if_instrn, 32'h2008_0005);
    chk("first_pc4", if_pc_plus4, 32'd4);
    chk("first_count", fetch_count, 32'd1);
    for (int i = 0; i < 7; i++) cycle();
    chk("seq_count", fetch_count, 32'd8);
    cycle();
    chk("oor_fault", 32'(fetch_fault), 32'd1);
    chk("oor_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("oor_hold_addr", instrn_address, 32'd32);
    end

    // Mid-run asynchronous reset from HALT, then a backward branch
    do_reset();
    cycle();
    cycle();
    chk("pre_branch_pc4", if_pc_plus4, 32'd8);
    branch_taken = 1; branch_offset = 16'hFFFE;
    cycle();
    chk("br_addr", instrn_address, 32'd0);
    chk("br_bubble", 32'(if_valid), 32'd0);
    clear_inputs();
    cycle();
    chk("br_target_instr", if_instrn, 32'h2008_0005);

    // Redirect priority, then a misaligned JR target
    jump_reg = 1; branch_taken = 1; branch_offset = 16'h0001; jr_target = 32'h10;
    cycle();
    chk("jr_prio_addr", instrn_address, 32'h10);
    clear_inputs();
    cycle();
    chk("jr_target_instr", if_instrn, mem[4]);
    jump_reg = 1; jr_target = 32'h12;
    cycle();
    chk("jr_misalign_fault", 32'(fetch_fault), 32'd1);
    clear_inputs();
    cycle();

    // Stall holds everything and defers the jump
    do_reset();
    cycle();
    cycle();
    jump = 1; jump_target = 26'd5; stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr", instrn_address, 32'd8);
      chk("stall_count", fetch_count, 32'd2);
      chk("stall_pc4", if_pc_plus4, 32'd8);
    end
    stall = 0;
    cycle();
    chk("jump_addr", instrn_address, 32'h14);
    clear_inputs();
    cycle();
    chk("jump_instr", if_instrn, mem[5]);

    // Random traffic
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
      do_reset();
      halt_cycles = 0;
      for (int c = 0; c < 80 && halt_cycles < 3; c++) begin
        clear_inputs();
        stall = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        if (r == 0) begin
          jump_reg = 1;
          jr_target = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 40))
                                                   : 32'($urandom_range(0, WORDS - 1) * 4);
        end else if (r == 1) begin
          jump = 1; jump_target = 26'($urandom_range(0, WORDS));
        end else if (r == 2) begin
          branch_taken = 1; branch_offset = 16'($signed($urandom_range(0, 12)) - 6);
        end
        if ($urandom_range(0, 3) == 0) jr_target = $urandom();
        cycle();
        if (m_halt) halt_cycles++;
      end
    end

    clear_inputs();
    cycle();
    chk("final_sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
